// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StHold
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect load takes priority over sequential increment.
module pc_reg #(
   parameter int unsigned         WIDTH    = 32,
   parameter logic [WIDTH-1:0]    RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_pc,
   input  logic             inc,
   output logic [WIDTH-1:0] pc
);

   logic [WIDTH-1:0] pc_q;

   // Increment wraps naturally modulo 2^WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load) begin
         pc_q <= load_pc;
      end else if (inc) begin
         pc_q <= pc_q + WIDTH'(4);
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time and hands (pc, instr) pairs to IF/ID.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_id_wr,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] instr_out
);

   localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INSTR);

   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] buf_pc_q, buf_instr_q;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] redirect_aligned;
   logic             active_redirect;
   logic             accept;
   logic             unused_redirect_lsbs;

   assign redirect_aligned     = {redirect_pc[WIDTH-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Redirect is ignored only while leaving reset (IDLE); a same-cycle response is dropped.
   assign active_redirect = redirect && (state_q != StIdle);
   assign accept          = (state_q == StReq) && imem_ready && !active_redirect;

   pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (active_redirect),
      .load_pc (redirect_aligned),
      .inc     (accept),
      .pc      (pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_pc_q    <= '0;
         buf_instr_q <= NOP_W;
      end else if (active_redirect) begin
         buf_pc_q    <= '0;
         buf_instr_q <= NOP_W;
      end else if (accept) begin
         buf_pc_q    <= pc;
         buf_instr_q <= imem_rdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      imem_req  = (state_q == StReq);
      if_id_wr  = 1'b0;
      pc_out    = buf_pc_q;
      instr_out = buf_instr_q;

      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (imem_ready) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if_id_wr = !stall;
            if (!stall) begin
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase

      // Flush bubble; only written when IF/ID can take it.
      if (active_redirect) begin
         state_d   = StReq;
         if_id_wr  = !stall;
         pc_out    = '0;
         instr_out = NOP_W;
      end
   end

   assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected IF/ID writes.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } pair_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   logic        imem_req, if_id_wr;
   logic [31:0] imem_addr, pc_out, instr_out;
   logic        w_imem_req, w_if_id_wr;
   logic [31:0] w_imem_addr, w_pc_out, w_instr_out;

   int    checks = 0;
   int    errors = 0;
   int    pulses = 0;
   int    p0;
   pair_t sb[$];
   pair_t exp_pair;

   fetch_unit #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_wr    (if_id_wr),
      .pc_out      (pc_out),
      .instr_out   (instr_out)
   );

   fetch_unit #(
      .WIDTH    (32),
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_w (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (w_imem_req),
      .imem_addr   (w_imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_wr    (w_if_id_wr),
      .pc_out      (w_pc_out),
      .instr_out   (w_instr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Every IF/ID write must match the oldest expected pair.
   always @(negedge clk) begin
      if (!rst && if_id_wr === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            chk("unexpected_wr", pc_out, 32'hXXXX_XXXX);
         end else begin
            exp_pair = sb.pop_front();
            chk("wr_pc", pc_out, exp_pair.pc);
            chk("wr_instr", instr_out, exp_pair.instr);
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      adv(); adv();
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_wr", 32'(if_id_wr), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_addr_w", w_imem_addr, 32'hFFFF_FFFC);
      adv();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req", 32'(imem_req), 32'd0);
      adv();

      // First fetch with imem_ready tied high
      imem_ready = 1'b1; imem_rdata = 32'hA000_0001;
      sb.push_back('{pc: 32'h0, instr: 32'hA000_0001});
      @(negedge clk);
      chk("req1_req", 32'(imem_req), 32'd1);
      chk("req1_addr", imem_addr, 32'h0);
      chk("req1_addr_w", w_imem_addr, 32'hFFFF_FFFC);
      adv();
      @(negedge clk);
      chk("hold1_req", 32'(imem_req), 32'd0);
      chk("hold1_wr", 32'(if_id_wr), 32'd1);
      adv();
      imem_rdata = 32'hA000_0002;
      sb.push_back('{pc: 32'h4, instr: 32'hA000_0002});
      @(negedge clk);
      chk("req2_addr", imem_addr, 32'h4);
      chk("wrap_addr_w", w_imem_addr, 32'h0);
      adv();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("hold2_wr", 32'(if_id_wr), 32'd1);
      adv();

      // Memory response delayed three cycles
      p0 = pulses;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_addr", imem_addr, 32'h8);
         chk("wait_wr", 32'(if_id_wr), 32'd0);
         adv();
      end
      imem_ready = 1'b1; imem_rdata = 32'hB000_0003;
      sb.push_back('{pc: 32'h8, instr: 32'hB000_0003});
      @(negedge clk);
      chk("late_addr", imem_addr, 32'h8);
      adv();

      // Stall held four cycles in HOLD
      imem_ready = 1'b0; stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_wr", 32'(if_id_wr), 32'd0);
         chk("stall_pc", pc_out, 32'h8);
         chk("stall_instr", instr_out, 32'hB000_0003);
         adv();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("unstall_wr", 32'(if_id_wr), 32'd1);
      adv();
      chk("single_pulse", 32'(pulses), 32'(p0 + 1));

      // Redirect in HOLD without stall drops the buffered pair
      imem_ready = 1'b1; imem_rdata = 32'hC000_0004;
      sb.push_back('{pc: 32'hC, instr: 32'hC000_0004});
      @(negedge clk);
      chk("req4_addr", imem_addr, 32'hC);
      adv();
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
      void'(sb.pop_back());
      sb.push_back('{pc: 32'h0, instr: NOP});
      @(negedge clk);
      chk("bubble_wr", 32'(if_id_wr), 32'd1);
      chk("bubble_instr", instr_out, NOP);
      chk("bubble_pc", pc_out, 32'h0);
      adv();
      redirect = 1'b0;
      @(negedge clk);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      chk("redir_req", 32'(imem_req), 32'd1);

      // Redirect colliding with a response while stalled
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("coll_wr", 32'(if_id_wr), 32'd0);
      adv();
      stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      chk("coll_addr", imem_addr, 32'h0000_0200);
      chk("coll_wr2", 32'(if_id_wr), 32'd0);
      chk("coll_req", 32'(imem_req), 32'd1);
      imem_ready = 1'b1; imem_rdata = 32'hE000_0005;
      sb.push_back('{pc: 32'h200, instr: 32'hE000_0005});
      adv();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("post_coll_wr", 32'(if_id_wr), 32'd1);
      adv();

      // Asynchronous reset in the middle of a request
      @(negedge clk);
      chk("pre_rst_addr", imem_addr, 32'h0000_0204);
      #2 rst = 1'b1;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_instr", instr_out, NOP);
      imem_ready = 1'b1; imem_rdata = 32'hF00D_0006;
      adv(); adv();
      rst = 1'b0;
      @(negedge clk);
      chk("rel_req", 32'(imem_req), 32'd0);
      chk("rel_wr", 32'(if_id_wr), 32'd0);
      adv();
      sb.push_back('{pc: 32'h0, instr: 32'hF00D_0006});
      @(negedge clk);
      chk("rel_addr", imem_addr, 32'h0);
      adv();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("rel_wr2", 32'(if_id_wr), 32'd1);
      adv(); adv();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the datapath width for PC and instruction.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: IF/ID cannot accept a new pair this cycle.
REQ-006 The block SHALL have port redirect, input, 1 bit: branch/jump taken; refetch from redirect_pc.
REQ-007 The block SHALL have port redirect_pc, input, WIDTH bits: the redirect target.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-009 The block SHALL have port imem_addr, output, WIDTH bits: the read address.
REQ-010 The block SHALL have port imem_ready, input, 1 bit: imem_rdata is valid this cycle.
REQ-011 The block SHALL have port imem_rdata, input, WIDTH bits: the fetched instruction word.
REQ-012 The block SHALL have port if_id_wr, output, 1 bit: the write enable of the IF/ID register.
REQ-013 The block SHALL have port pc_out, output, WIDTH bits: the PC presented to IF/ID.
REQ-014 The block SHALL have port instr_out, output, WIDTH bits: the instruction presented to IF/ID.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-016 IDLE SHALL go to REQ unconditionally on the first clock after reset release.
REQ-017 In REQ: imem_req=1 and imem_addr=pc; on imem_ready, buf_pc<=pc, buf_instr<=imem_rdata, pc<=pc+4, and the FSM SHALL go to HOLD.
REQ-018 In REQ without imem_ready, the FSM SHALL remain in REQ with pc and imem_addr unchanged.
REQ-019 In HOLD: pc_out=buf_pc, instr_out=buf_instr, if_id_wr=!stall, and imem_req=0.
REQ-020 In HOLD with !stall, the FSM SHALL go to REQ next cycle; with stall, it SHALL remain in HOLD with buffers held.
REQ-021 Outside HOLD, if_id_wr SHALL be 0 unless REQ-022 applies; latency is one cycle from imem_ready to the if_id_wr pulse.
REQ-022 Redirect SHALL override all other conditions in any non-IDLE state: pc<=redirect_pc with bits [1:0] forced to 0, state<=REQ, the buffered pair discarded, and a same-cycle imem_ready/imem_rdata ignored.
REQ-023 On redirect with !stall: if_id_wr=1, instr_out=NOP (32'h0000_0013), pc_out=0 (flush bubble).
REQ-024 On redirect with stall: if_id_wr=0, no bubble written, and the redirect still takes effect.
REQ-025 PC arithmetic SHALL be modulo 2^WIDTH: 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 An outstanding request abandoned by a redirect SHALL be dropped; imem_addr shows the new pc in the following cycle.

Reset
REQ-027 While rst is high, the block SHALL hold: state=IDLE, pc=RESET_PC, buf_pc=0, buf_instr=NOP, imem_req=0, if_id_wr=0.
REQ-028 While rst is high, imem_addr=RESET_PC, pc_out=0, instr_out=NOP.
REQ-029 Reset asserted mid-transaction SHALL abort immediately (asynchronously); any later imem_ready SHALL be ignored until state is REQ.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum fetch_state_t and the constant NOP_INSTR = 32'h0000_0013.
REQ-031 The PC register with load/increment SHALL be one sub-module, pc_reg; all other logic SHALL be inline.

Verification
REQ-032 Reset release with imem_ready tied 1 -> imem_req rises one cycle after release, imem_addr=0; if_id_wr pulses with pc_out=0, instr_out=rdata; the next fetch is at addr 4.
REQ-033 imem_ready delayed 3 cycles in REQ -> imem_addr is stable for all 3 cycles; if_id_wr pulses exactly once afterwards.
REQ-034 stall held 4 cycles while in HOLD -> if_id_wr=0 and pc_out/instr_out are constant; one if_id_wr pulse follows stall release.
REQ-035 redirect to 32'h0000_0103 in HOLD, no stall -> if_id_wr=1 with instr_out=32'h0000_0013; the next imem_addr=32'h0000_0100.
REQ-036 redirect and imem_ready in the same cycle, with stall=1 -> rdata is discarded, if_id_wr=0, and the next imem_addr=redirect target.
REQ-037 RESET_PC=32'hFFFF_FFFC -> the second fetch address is 32'h0000_0000.
